switch_debouncer: RTL and testbench



---
 rtl/sw_io_pkg.sv | 17 +
 rtl/debounce_bit.sv | 58 +++++
 rtl/switch_debouncer.sv | 70 +++++++
 tb/tb_switch_debouncer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_io_pkg.sv
// Shared constants and helpers for the switch input-conditioning path.
// Contents:
//   NUM_SW_DEFAULT, SYNC_STAGES_DEFAULT, DEBOUNCE_CYCLES_DEFAULT, DEBOUNCE_CYCLES_SIM
//   cnt_width(n) : bits needed to hold 0..n
package sw_io_pkg;

    localparam int unsigned NUM_SW_DEFAULT          = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

    // Width of a counter able to represent 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain, stability counter, stable level and
// single-cycle rise/fall pulses.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   raw       : asynchronous switch input
//   stable    : debounced level
//   rise/fall : one-cycle pulse on accepted 0->1 / 1->0
//   change_c  : combinational accept strobe (high on the edge that updates stable)
module debounce_bit
    import sw_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic change_c
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign change_c = (synced != stable) && (cnt == CNT_LAST);

    // Synchronizer, counter, stable level and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= change_c & synced;
            fall   <= change_c & ~synced;
            // Any return to the stable value restarts the count.
            if (synced == stable) begin
                cnt <= '0;
            end else if (change_c) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Board switch conditioning: per-bit synchronize + debounce, with clean
// levels and rise/fall pulses. Optional sticky change flags and irq are
// built when SW_CHANGE_IRQ_EN is defined; otherwise they read 0.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   switches_raw   : asynchronous switch inputs
//   switches       : debounced levels
//   sw_rise/sw_fall: one-cycle pulses on accepted transitions
//   flags_clr      : write-1-to-clear for change_flags
//   change_flags   : sticky per-bit change flags
//   irq            : OR of change_flags
module switch_debouncer
    import sw_io_pkg::*;
#(
    parameter int unsigned NUM_SW          = NUM_SW_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] switches_raw,
    output logic [NUM_SW-1:0] switches,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    input  logic [NUM_SW-1:0] flags_clr,
    output logic [NUM_SW-1:0] change_flags,
    output logic              irq
);

    logic [NUM_SW-1:0] change_c;

    // Independent debouncer per switch bit.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw      (switches_raw[i]),
            .stable   (switches[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i]),
            .change_c (change_c[i])
        );
    end

`ifdef SW_CHANGE_IRQ_EN
    logic [NUM_SW-1:0] flags_q;

    // Sticky flags set on the same edge as the pulses; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= (flags_q & ~flags_clr) | change_c;
        end
    end

    assign change_flags = flags_q;
    assign irq          = |flags_q;
`else
    logic unused_inputs;

    assign change_flags  = '0;
    assign irq           = 1'b0;
    assign unused_inputs = ^{flags_clr, change_c};
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Stimulus pushes expected pulse events; a negedge monitor pops and compares
// whenever a rise/fall pulse appears.
module tb_switch_debouncer;
    import sw_io_pkg::*;

    localparam int unsigned N   = 16;
    localparam int unsigned SS  = 2;
    localparam int unsigned DC  = DEBOUNCE_CYCLES_SIM;
    localparam int unsigned LAT = SS + DC;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] clr;
    logic [N-1:0] switches;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic [N-1:0] change_flags;
    logic         irq;

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] sw;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } ev_t;

    ev_t         q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned c0;

    switch_debouncer #(
        .NUM_SW          (N),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .switches_raw (raw),
        .switches     (switches),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .flags_clr    (clr),
        .change_flags (change_flags),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [N-1:0] sw, input logic [N-1:0] r,
                             input logic [N-1:0] f, input int unsigned at);
        ev_t e;
        e.cyc  = at;
        e.sw   = sw;
        e.rise = r;
        e.fall = f;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_sw"},    32'(switches), 32'h0);
        chk({name, "_pulse"}, 32'(sw_rise | sw_fall), 32'h0);
        chk({name, "_irq"},   32'(irq), 32'h0);
        chk({name, "_flags"}, 32'(change_flags), 32'h0);
    endtask

    // Monitor: pops one expected event per pulse cycle.
    ev_t m;
    always @(negedge clk) begin
        if (!rst) begin
            chk("irq_is_or", 32'(irq), 32'(|change_flags));
`ifndef SW_CHANGE_IRQ_EN
            chk("flags_tied", 32'(change_flags), 32'h0);
`endif
            chk("rise_fall_excl", 32'(sw_rise & sw_fall), 32'h0);
            if ((sw_rise | sw_fall) != '0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got rise=%0h fall=%0h want none (cycle %0d)",
                             sw_rise, sw_fall, cyc);
                end else begin
                    m = q.pop_front();
                    chk("ev_cycle", m.cyc == cyc ? 32'(cyc) : 32'(cyc), 32'(m.cyc));
                    chk("ev_sw",    32'(switches), 32'(m.sw));
                    chk("ev_rise",  32'(sw_rise),  32'(m.rise));
                    chk("ev_fall",  32'(sw_fall),  32'(m.fall));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        raw = '0;
        clr = '0;

        // Reset for two cycles, then idle.
        tick(1); chk_idle("rst1");
        tick(1); chk_idle("rst2");
        rst = 1'b0;
        tick(1); chk_idle("post_rst1");
        tick(2); chk_idle("post_rst2");

        // Level step up, exact latency.
        raw = 16'hAAAA;
        expect_ev(16'hAAAA, 16'hAAAA, 16'h0000, cyc + LAT);
        tick(LAT - 1); chk("step_up_pre",  32'(switches), 32'h0);
        tick(1);       chk("step_up_post", 32'(switches), 32'hAAAA);
        tick(4);

        // Level step down.
        raw = 16'h0000;
        expect_ev(16'h0000, 16'h0000, 16'hAAAA, cyc + LAT);
        tick(LAT - 1); chk("step_dn_pre",  32'(switches), 32'hAAAA);
        tick(1);       chk("step_dn_post", 32'(switches), 32'h0);
        tick(4);

        // Glitch: bit0 high for 3 cycles is rejected.
        raw = 16'h0001;
        tick(3);
        raw = 16'h0000;
        tick(10); chk("glitch_sw", 32'(switches), 32'h0);

        // Bounce on bit3, then hold high.
        for (int i = 0; i < 10; i++) begin
            raw = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            tick(1);
        end
        raw = 16'h0008;
        expect_ev(16'h0008, 16'h0008, 16'h0000, cyc + LAT);
        tick(LAT - 1); chk("bounce_pre",  32'(switches), 32'h0);
        tick(1);       chk("bounce_post", 32'(switches), 32'h0008);
        tick(4);
        raw = 16'h0000;
        expect_ev(16'h0000, 16'h0000, 16'h0008, cyc + LAT);
        tick(LAT + 4);
        chk("bounce_release", 32'(switches), 32'h0);

        // Reset mid-count on bit5; switch stays high through reset.
        raw = 16'h0020;
        tick(3);
        rst = 1'b1;
        tick(1); chk_idle("mid_rst");
        rst = 1'b0;
        expect_ev(16'h0020, 16'h0020, 16'h0000, cyc + LAT);
        tick(LAT - 1); chk("mid_rst_pre",  32'(switches), 32'h0);
        tick(1);       chk("mid_rst_post", 32'(switches), 32'h0020);
        tick(3);
        raw = 16'h0000;
        expect_ev(16'h0000, 16'h0000, 16'h0020, cyc + LAT);
        tick(LAT + 4);

`ifdef SW_CHANGE_IRQ_EN
        // Sticky flag set, cleared, and set-wins-over-clear.
        raw = 16'h0004;
        expect_ev(16'h0004, 16'h0004, 16'h0000, cyc + LAT);
        tick(LAT);
        chk("flag_set",     32'(change_flags), 32'h0004);
        chk("flag_set_irq", 32'(irq), 32'h1);
        tick(2);
        chk("flag_sticky",  32'(change_flags), 32'h0004);
        clr = 16'h0004;
        tick(1);
        clr = '0;
        chk("flag_clr",     32'(change_flags), 32'h0);
        chk("flag_clr_irq", 32'(irq), 32'h0);
        raw = 16'h0000;
        c0  = cyc;
        expect_ev(16'h0000, 16'h0000, 16'h0004, c0 + LAT);
        tick(LAT - 1);
        clr = 16'h0004;
        tick(1);
        clr = '0;
        chk("flag_set_wins",     32'(change_flags), 32'h0004);
        chk("flag_set_wins_irq", 32'(irq), 32'h1);
        clr = 16'h0004;
        tick(1);
        clr = '0;
        chk("flag_final_clr", 32'(change_flags), 32'h0);
        tick(2);
`endif

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d pending want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
